// File: rtl/message_packet_arbiter.sv
// message_packet_arbiter: round-robin arbiter that forwards whole packets
// (header word plus L body words) from N_STREAMS show-ahead FIFOs onto a
// single registered message stream with downstream backpressure.
// Header words carry bit WIDTH-1 set and the body length in the next
// LOG_MAX_PACKET_LENGTH bits. A non-header word seen in IDLE is dropped and
// raises the sticky error flag.
// Optional: define MESSAGE_PACKET_ARBITER_TIMEOUT_EN to abandon a packet whose
// locked stream stays empty for TIMEOUT_CYCLES ready cycles.
module message_packet_arbiter #(
    parameter int N_STREAMS             = 4,
    parameter int LOG_N_STREAMS         = 2,
    parameter int WIDTH                 = 32,
    parameter int LOG_MAX_PACKET_LENGTH = 10,
    parameter int TIMEOUT_CYCLES        = 256,
    parameter int LOG_TIMEOUT_CYCLES    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH*N_STREAMS-1:0]   in_data,
    input  logic [N_STREAMS-1:0]         in_valid,
    output logic [N_STREAMS-1:0]         in_read,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_nd,
    output logic [LOG_N_STREAMS-1:0]     out_stream,
    output logic                         error
);

    localparam int unsigned NS = N_STREAMS;

    // Elaboration-time sanity checks on the configuration.
    if (N_STREAMS < 2) begin : g_bad_streams
        $error("message_packet_arbiter: N_STREAMS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << LOG_TIMEOUT_CYCLES)) begin : g_bad_timeout
        $error("message_packet_arbiter: TIMEOUT_CYCLES does not fit LOG_TIMEOUT_CYCLES");
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_PACKET = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [LOG_N_STREAMS-1:0]         r_ptr;
    logic [LOG_N_STREAMS-1:0]         w_ptr_nxt;
    logic [LOG_N_STREAMS-1:0]         r_locked;
    logic [LOG_N_STREAMS-1:0]         w_locked_nxt;
    logic [LOG_MAX_PACKET_LENGTH-1:0] r_remaining;
    logic [LOG_MAX_PACKET_LENGTH-1:0] w_remaining_nxt;
    logic [WIDTH-1:0]                 r_out_data;
    logic                             r_out_nd;
    logic [LOG_N_STREAMS-1:0]         r_out_stream;
    logic                             r_error;

    logic                             w_gnt_any;
    logic [LOG_N_STREAMS-1:0]         w_gnt_idx;
    logic                             w_pop;
    logic [WIDTH-1:0]                 w_word;
    logic                             w_is_hdr;
    logic [LOG_MAX_PACKET_LENGTH-1:0] w_len;
    logic                             w_emit;
    logic                             w_err_set;
    logic                             w_timeout;

    function automatic logic [LOG_N_STREAMS-1:0] wrap_inc(input logic [LOG_N_STREAMS-1:0] s);
        if (int'(s) >= N_STREAMS - 1) begin
            return '0;
        end
        return s + LOG_N_STREAMS'(1);
    endfunction

    // Grant selection: locked stream in PACKET, else first valid from ptr onward.
    always_comb begin
        int unsigned               cand;
        logic [LOG_N_STREAMS-1:0]  cidx;
        w_gnt_any = 1'b0;
        w_gnt_idx = r_ptr;
        cand      = 0;
        cidx      = '0;
        if (r_state == S_PACKET) begin
            w_gnt_idx = r_locked;
            w_gnt_any = in_valid[r_locked];
        end else begin
            for (int unsigned k = 0; k < NS; k++) begin
                cand = int'(r_ptr) + k;
                if (cand >= NS) begin
                    cand = cand - NS;
                end
                cidx = LOG_N_STREAMS'(cand);
                if (!w_gnt_any && in_valid[cidx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = cidx;
                end
            end
        end
    end

    assign w_pop    = w_gnt_any & out_ready & ~rst;
    assign w_is_hdr = w_word[WIDTH-1];
    assign w_len    = w_word[WIDTH-2 -: LOG_MAX_PACKET_LENGTH];

    // Head-word mux and one-hot pop strobe for the granted stream.
    always_comb begin
        w_word  = '0;
        in_read = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (w_gnt_idx == LOG_N_STREAMS'(s)) begin
                w_word     = in_data[WIDTH*s +: WIDTH];
                in_read[s] = w_pop;
            end
        end
    end

`ifdef MESSAGE_PACKET_ARBITER_TIMEOUT_EN
    logic [LOG_TIMEOUT_CYCLES-1:0] r_wd;

    assign w_timeout = (r_state == S_PACKET) && !in_valid[r_locked] && out_ready &&
                       (r_wd == LOG_TIMEOUT_CYCLES'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts ready cycles the locked stream sits empty; idle in IDLE.
    always_ff @(posedge clk) begin
        if (rst || w_pop || r_state != S_PACKET || w_timeout) begin
            r_wd <= '0;
        end else if (!in_valid[r_locked] && out_ready) begin
            r_wd <= r_wd + LOG_TIMEOUT_CYCLES'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic for packet framing and round-robin pointer.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_locked_nxt    = r_locked;
        w_remaining_nxt = r_remaining;
        w_emit          = 1'b0;
        w_err_set       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    if (w_is_hdr) begin
                        w_emit = 1'b1;
                        if (w_len != '0) begin
                            w_state_nxt     = S_PACKET;
                            w_locked_nxt    = w_gnt_idx;
                            w_remaining_nxt = w_len;
                        end else begin
                            w_ptr_nxt = wrap_inc(w_gnt_idx);
                        end
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_PACKET: begin
                if (w_pop) begin
                    w_emit          = 1'b1;
                    w_remaining_nxt = r_remaining - LOG_MAX_PACKET_LENGTH'(1);
                    if (r_remaining == LOG_MAX_PACKET_LENGTH'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = wrap_inc(r_locked);
                    end
                end else if (w_timeout) begin
                    w_state_nxt     = S_IDLE;
                    w_ptr_nxt       = wrap_inc(r_locked);
                    w_remaining_nxt = '0;
                    w_err_set       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_locked     <= '0;
            r_remaining  <= '0;
            r_out_data   <= '0;
            r_out_nd     <= 1'b0;
            r_out_stream <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_locked    <= w_locked_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_nd    <= w_emit;
            if (w_emit) begin
                r_out_data   <= w_word;
                r_out_stream <= w_gnt_idx;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_nd     = r_out_nd;
    assign out_stream = r_out_stream;
    assign error      = r_error;

endmodule

// File: tb/tb_message_packet_arbiter.sv
// Testbench for message_packet_arbiter: per-stream FIFO models feed the DUT,
// directed packets push hand-computed expected words into a scoreboard
// queue, and a forked monitor pops and compares on every out_nd.
module tb_message_packet_arbiter;

    localparam int N  = 4;
    localparam int LN = 2;
    localparam int W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [W*N-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_read;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_nd;
    logic [LN-1:0]     out_stream;
    logic              error;

    always #5 clk = ~clk;

`ifdef MESSAGE_PACKET_ARBITER_TIMEOUT_EN
    message_packet_arbiter #(
        .N_STREAMS(N), .LOG_N_STREAMS(LN), .WIDTH(W), .LOG_MAX_PACKET_LENGTH(10),
        .TIMEOUT_CYCLES(4), .LOG_TIMEOUT_CYCLES(3)
    ) dut (
`else
    message_packet_arbiter #(
        .N_STREAMS(N), .LOG_N_STREAMS(LN), .WIDTH(W), .LOG_MAX_PACKET_LENGTH(10)
    ) dut (
`endif
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_read(in_read), .out_ready(out_ready), .out_data(out_data),
        .out_nd(out_nd), .out_stream(out_stream), .error(error)
    );

    int                checks = 0;
    int                errors = 0;
    int                mon_cyc = 0;
    logic [W-1:0]      mem [N][16];
    logic [3:0]        hd [N];
    logic [3:0]        tl [N];
    logic [LN+W-1:0]   exp_q [$];
    int                out_cyc [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] hdr(input int l, input logic [20:0] tag);
        return {1'b1, 10'(l), tag};
    endfunction

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            in_valid[s]       = (hd[s] != tl[s]);
            in_data[W*s +: W] = in_valid[s] ? mem[s][hd[s]] : '0;
        end
    endtask

    task automatic push(input int s, input logic [31:0] w);
        mem[s][tl[s]] = w;
        tl[s] = tl[s] + 4'd1;
        drive();
    endtask

    task automatic expect_word(input int s, input logic [31:0] w);
        exp_q.push_back({LN'(s), w});
    endtask

    task automatic tick();
        logic [N-1:0] rd;
        @(negedge clk);
        rd = in_read;
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++) begin
            if (rd[s] && hd[s] != tl[s]) hd[s] = hd[s] + 4'd1;
        end
        drive();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic chk_burst(input string name);
        if (out_cyc.size() > 0)
            chk(name, 64'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 64'(out_cyc.size() - 1));
    endtask

    task automatic monitor();
        logic            prev_pop = 1'b0;
        logic [LN+W-1:0] e;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst) begin
                prev_pop = 1'b0;
            end else begin
                if (out_nd) begin
                    chk("nd_follows_pop", 64'(prev_pop), 64'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%0h/%0h required=none", out_stream, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(e[W-1:0]));
                        chk("out_stream", 64'(out_stream), 64'(e[LN+W-1:W]));
                        out_cyc.push_back(mon_cyc);
                    end
                end
                chk("in_read_onehot", 64'($countones(in_read) <= 1), 64'd1);
                if (in_read != '0) chk("read_needs_ready", 64'(out_ready), 64'd1);
                prev_pop = |in_read;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        for (int s = 0; s < N; s++) begin
            hd[s] = '0;
            tl[s] = '0;
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        drive();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_nd", 64'(out_nd), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_stream", 64'(out_stream), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_in_read", 64'(in_read), 64'd0);

        // Single L=3 packet on stream 2; ptr becomes 3.
        out_cyc.delete();
        push(2, hdr(3, 21'h1)); push(2, 32'h11); push(2, 32'h22); push(2, 32'h33);
        expect_word(2, hdr(3, 21'h1)); expect_word(2, 32'h11);
        expect_word(2, 32'h22); expect_word(2, 32'h33);
        wait_drain("drain_t1", 20);
        chk_burst("t1_consecutive");
        chk("t1_error", 64'(error), 64'd0);

        // Streams 0 and 1 together; search from ptr=3 wraps to 0 first.
        out_cyc.delete();
        push(0, hdr(1, 21'h2)); push(0, 32'h44);
        push(1, hdr(1, 21'h3)); push(1, 32'h55);
        expect_word(0, hdr(1, 21'h2)); expect_word(0, 32'h44);
        expect_word(1, hdr(1, 21'h3)); expect_word(1, 32'h55);
        wait_drain("drain_t2", 20);
        chk_burst("t2_back_to_back");

        // Stream 1 stalls mid-packet while stream 3 is valid.
        push(1, hdr(3, 21'h4)); push(1, 32'h66);
        expect_word(1, hdr(3, 21'h4)); expect_word(1, 32'h66);
        expect_word(1, 32'h77); expect_word(1, 32'h88);
        expect_word(3, hdr(0, 21'h5));
        tick();
        push(3, hdr(0, 21'h5));
        for (int i = 0; i < 6; i++) tick();
        chk("t3_stall_hold", 64'(exp_q.size()), 64'd3);
        push(1, 32'h77); push(1, 32'h88);
        wait_drain("drain_t3", 20);

        // Non-header word in IDLE is dropped and sets error; ptr wrapped to 0.
        chk("t4_error_before", 64'(error), 64'd0);
        push(0, 32'h0000_0005); push(0, hdr(0, 21'h0AAA));
        expect_word(0, hdr(0, 21'h0AAA));
        wait_drain("drain_t4", 20);
        tick();
        chk("t4_error_set", 64'(error), 64'd1);

        // out_ready toggling during an L=2 packet on stream 1.
        push(1, hdr(2, 21'h6)); push(1, 32'h99); push(1, 32'hAA);
        expect_word(1, hdr(2, 21'h6)); expect_word(1, 32'h99); expect_word(1, 32'hAA);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain("drain_t5", 5);
        chk("t5_fifo_empty", 64'(in_valid[1]), 64'd0);
        chk("t5_error_sticky", 64'(error), 64'd1);

        // Reset mid-packet: leftover body words become invalid headers.
        out_ready = 1'b0;
        push(2, hdr(3, 21'h7)); push(2, 32'hB1); push(2, 32'hB2); push(2, 32'hB3);
        expect_word(2, hdr(3, 21'h7)); expect_word(2, 32'hB1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        wait_drain("drain_t6", 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_error", 64'(error), 64'd0);
        chk("t6_rst_nd", 64'(out_nd), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_bodies_popped", 64'(in_valid[2]), 64'd0);
        chk("t6_error_after", 64'(error), 64'd1);

`ifdef MESSAGE_PACKET_ARBITER_TIMEOUT_EN
        // Truncated packet on stream 0 times out; stream 1 granted next.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(0, hdr(5, 21'h8)); push(1, hdr(0, 21'h9));
        expect_word(0, hdr(5, 21'h8)); expect_word(1, hdr(0, 21'h9));
        wait_drain("drain_timeout", 30);
        chk("timeout_error", 64'(error), 64'd1);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_packet_arbiter.md
Name: message_packet_arbiter

Overview:
- Round-robin scheduler that shares one message-stream output between N_STREAMS requester FIFOs, granting whole packets atomically (header plus L body words).
- Sits between per-source FIFOs (show-ahead, non-empty flag plus pop) and a single downstream message consumer with backpressure.
- Replaces free-running stream interleaving with explicit fairness, backpressure and header checking.

Parameters:
- N_STREAMS, 4, number of requesters; must be at least 2.
- LOG_N_STREAMS, 2, width of the stream index.
- WIDTH, 32, message word width.
- LOG_MAX_PACKET_LENGTH, 10, width of the header length field.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature).
- LOG_TIMEOUT_CYCLES, 8, width of the watchdog counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  WIDTH*N_STREAMS  head word of each FIFO; stream s occupies bits [WIDTH*(s+1)-1 -: WIDTH].
- in_valid  in  N_STREAMS  FIFO s is non-empty and in_data for s is valid.
- in_read  out  N_STREAMS  combinational pop strobe; at most one bit is high in any cycle.
- out_ready  in  1  downstream can accept a word this cycle.
- out_data  out  WIDTH  registered output word.
- out_nd  out  1  out_data is valid for one cycle.
- out_stream  out  LOG_N_STREAMS  source stream of the current out_data.
- error  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Word format:
  - Bit WIDTH-1 = 1 marks a header.
  - Length L = bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH].
  - A packet is 1+L words. L=0 is a single-word packet.
- Reset values: out_data=0, out_nd=0, out_stream=0, error=0, state=IDLE, ptr=0, remaining=0, locked=0, in_read=0.
- Pop rule: a pop on stream s occurs when in_read[s]=in_valid[s]&grant[s]&out_ready. Registered outputs update on the next edge.
- Latency: exactly 1 cycle from pop to out_nd=1, carrying the popped word and out_stream=s. out_nd=0 in every cycle following a cycle with no pop.
- IDLE state:
  - grant is the first s with in_valid[s]=1, searching ptr, ptr+1, ... with wrap mod N_STREAMS.
  - Header, L>0: state becomes PACKET, locked=s, remaining=L; the header word is output.
  - Header, L=0: output the word, ptr=s+1 mod N, stay in IDLE.
  - Non-header: the word is popped and discarded (out_nd=0 next cycle), error set, ptr unchanged, stay in IDLE.
  - No in_valid, or out_ready=0: no pop and no state change.
- PACKET state:
  - Only locked is granted; all other streams are ignored even if valid.
  - Each pop outputs the word (header bit not checked in the body) and decrements remaining.
  - A pop with remaining=1 sets state=IDLE and ptr=locked+1 mod N.
  - in_valid[locked]=0 or out_ready=0 stalls with no pop and holds state.
- Back-to-back operation: a packet may end and the next stream's header may pop in the very next cycle, with no bubble.
- ptr wrap: N_STREAMS-1 wraps to 0. Arithmetic is modulo the field widths; remaining is LOG_MAX_PACKET_LENGTH bits.
- Reset mid-packet: abandons the packet immediately. The next word after reset is treated as a header candidate.
- out_ready is sampled only for the pop decision. Words already registered on out_data are not retracted.

Optional Feature:
- Macro: MESSAGE_PACKET_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter clears on every pop and on entry to PACKET.
  - It increments in PACKET each cycle that in_valid[locked]=0 while out_ready=1.
  - On reaching TIMEOUT_CYCLES: state=IDLE, ptr=locked+1, error set; the truncated packet is not padded.
- When undefined: no counter exists, and PACKET waits forever for the locked stream.

Test Plan:
- Reset, then stream 2 presents header L=3 plus 3 body words, out_ready=1 → out_nd high for 4 consecutive cycles starting 1 cycle after the first pop; out_stream=2; ptr=3; error=0.
- Streams 0 and 1 each hold header L=1 plus 1 body word, both valid from the first cycle → output order s0h, s0b, s1h, s1b with no gap; in_read never has two bits set.
- Stream 1 mid-packet (remaining=2) stalls 5 cycles while stream 3 is valid → stream 3 is not granted; stream 1 completes, then stream 3 is granted next.
- Non-header word 0x0000_0005 at the head of stream 0 in IDLE → popped, out_nd stays 0, error=1 and sticky; the following header on stream 0 is forwarded normally.
- out_ready toggles 1,0,1,0 during an L=2 packet → in_read is asserted only in cycles where out_ready=1; 3 words output in order; none lost or duplicated.
- With TIMEOUT_EN and TIMEOUT_CYCLES=4: stream 0 sends header L=5 then stops → after 4 idle cycles state=IDLE, error=1, and stream 1 is granted next.
